// File: rtl/arp_tx.sv
// ARP payload transmitter: arbitrates local ARP requests against replies for arp_rx,
// requests the MAC transmit slot and streams the 46-byte payload one byte per clock.
module arp_tx #(
    parameter int FRAME_BYTES = 46
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] local_ip_addr,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] dest_ip_addr,
    input  logic        arp_request_req,
    input  logic        arp_reply_req,
    output logic        arp_reply_ack,
    input  logic [31:0] arp_rec_source_ip_addr,
    input  logic [47:0] arp_rec_source_mac_addr,
    output logic        arp_tx_req,
    input  logic        mac_tx_ack,
    output logic        arp_tx_valid,
    output logic [7:0]  arp_tx_data,
    output logic        arp_tx_end,
    output logic        arp_tx_type,
    output logic [47:0] arp_tx_dest_mac
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'b0001,
        S_WAIT_GRANT = 4'b0010,
        S_SEND       = 4'b0100,
        S_END        = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_pending_q, req_pending_d;
    logic        accept_req;

    logic        tx_req_q, tx_req_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        end_q, end_d;
    logic        ack_q, ack_d;
    logic        type_q, type_d;
    logic [47:0] dest_mac_q, dest_mac_d;

    logic [15:0] op_q, op_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [47:0] tha_q, tha_d;
    logic [31:0] tpa_q, tpa_d;

    // Byte map of the ARP body for Ethernet/IPv4; everything past byte 27 is pad.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]  idx,
        input logic [15:0] op,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            8'd0:  b = 8'h00;
            8'd1:  b = 8'h01;
            8'd2:  b = 8'h08;
            8'd3:  b = 8'h00;
            8'd4:  b = 8'h06;
            8'd5:  b = 8'h04;
            8'd6:  b = op[15:8];
            8'd7:  b = op[7:0];
            8'd8:  b = sha[47:40];
            8'd9:  b = sha[39:32];
            8'd10: b = sha[31:24];
            8'd11: b = sha[23:16];
            8'd12: b = sha[15:8];
            8'd13: b = sha[7:0];
            8'd14: b = spa[31:24];
            8'd15: b = spa[23:16];
            8'd16: b = spa[15:8];
            8'd17: b = spa[7:0];
            8'd18: b = tha[47:40];
            8'd19: b = tha[39:32];
            8'd20: b = tha[31:24];
            8'd21: b = tha[23:16];
            8'd22: b = tha[15:8];
            8'd23: b = tha[7:0];
            8'd24: b = tpa[31:24];
            8'd25: b = tpa[23:16];
            8'd26: b = tpa[15:8];
            8'd27: b = tpa[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_req = 1'b0;
        tx_req_d   = tx_req_q;
        valid_d    = 1'b0;
        data_d     = 8'h00;
        end_d      = 1'b0;
        ack_d      = 1'b0;
        type_d     = type_q;
        dest_mac_d = dest_mac_q;
        op_d       = op_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        tha_d      = tha_q;
        tpa_d      = tpa_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                if (arp_reply_req) begin
                    state_d    = S_WAIT_GRANT;
                    tx_req_d   = 1'b1;
                    ack_d      = 1'b1;
                    type_d     = 1'b1;
                    dest_mac_d = arp_rec_source_mac_addr;
                    op_d       = 16'h0002;
                    sha_d      = local_mac_addr;
                    spa_d      = local_ip_addr;
                    tha_d      = arp_rec_source_mac_addr;
                    tpa_d      = arp_rec_source_ip_addr;
                end else if (req_pending_q) begin
                    accept_req = 1'b1;
                    state_d    = S_WAIT_GRANT;
                    tx_req_d   = 1'b1;
                    type_d     = 1'b0;
                    dest_mac_d = 48'hFFFF_FFFF_FFFF;
                    op_d       = 16'h0001;
                    sha_d      = local_mac_addr;
                    spa_d      = local_ip_addr;
                    tha_d      = 48'h0;
                    tpa_d      = dest_ip_addr;
                end
            end
            S_WAIT_GRANT: begin
                if (mac_tx_ack) begin
                    state_d  = S_SEND;
                    tx_req_d = 1'b0;
                    cnt_d    = 8'd0;
                    valid_d  = 1'b1;
                    data_d   = frame_byte(8'd0, op_q, sha_q, spa_q, tha_q, tpa_q);
                end
            end
            S_SEND: begin
                // cnt_q indexes the byte currently on the output register.
                if (cnt_q == LAST_IDX) begin
                    state_d = S_END;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    valid_d = 1'b1;
                    data_d  = frame_byte(cnt_d, op_q, sha_q, spa_q, tha_q, tpa_q);
                    end_d   = (cnt_d == LAST_IDX);
                end
            end
            S_END: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // A pulse in the same cycle as acceptance re-arms the flag.
        req_pending_d = (req_pending_q & ~accept_req) | arp_request_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            req_pending_q <= 1'b0;
            tx_req_q      <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= 8'h00;
            end_q         <= 1'b0;
            ack_q         <= 1'b0;
            type_q        <= 1'b0;
            dest_mac_q    <= 48'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_pending_q <= req_pending_d;
            tx_req_q      <= tx_req_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            end_q         <= end_d;
            ack_q         <= ack_d;
            type_q        <= type_d;
            dest_mac_q    <= dest_mac_d;
        end
    end

    // Frame fields are only consumed after acceptance reloads them, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        sha_q <= sha_d;
        spa_q <= spa_d;
        tha_q <= tha_d;
        tpa_q <= tpa_d;
    end

    assign arp_tx_req      = tx_req_q;
    assign arp_tx_valid    = valid_q;
    assign arp_tx_data     = data_q;
    assign arp_tx_end      = end_q;
    assign arp_reply_ack   = ack_q;
    assign arp_tx_type     = type_q;
    assign arp_tx_dest_mac = dest_mac_q;

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: timeline-based reference model compared every cycle,
// plus directed scenarios with hand-computed payload bytes.
`timescale 1ns/1ps
module tb_arp_tx;
    localparam int F = 46;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] local_ip_addr = 32'hC0A8010A;
    logic [47:0] local_mac_addr = 48'h02AABBCCDDEE;
    logic [31:0] dest_ip_addr = 32'h0;
    logic        arp_request_req = 1'b0;
    logic        arp_reply_req = 1'b0;
    logic        arp_reply_ack;
    logic [31:0] arp_rec_source_ip_addr = 32'h0;
    logic [47:0] arp_rec_source_mac_addr = 48'h0;
    logic        arp_tx_req;
    logic        mac_tx_ack = 1'b0;
    logic        arp_tx_valid;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_end;
    logic        arp_tx_type;
    logic [47:0] arp_tx_dest_mac;

    arp_tx #(.FRAME_BYTES(F)) dut (
        .clk(clk), .rst_n(rst_n),
        .local_ip_addr(local_ip_addr), .local_mac_addr(local_mac_addr),
        .dest_ip_addr(dest_ip_addr),
        .arp_request_req(arp_request_req), .arp_reply_req(arp_reply_req),
        .arp_reply_ack(arp_reply_ack),
        .arp_rec_source_ip_addr(arp_rec_source_ip_addr),
        .arp_rec_source_mac_addr(arp_rec_source_mac_addr),
        .arp_tx_req(arp_tx_req), .mac_tx_ack(mac_tx_ack),
        .arp_tx_valid(arp_tx_valid), .arp_tx_data(arp_tx_data),
        .arp_tx_end(arp_tx_end), .arp_tx_type(arp_tx_type),
        .arp_tx_dest_mac(arp_tx_dest_mac)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: frames are scheduled by edge timestamps.
    int          m_n = 0;
    bit          m_wait = 0;
    int          m_grant = -1;
    bit          m_pend = 0;
    logic [7:0]  m_frame [0:255];
    bit          e_req = 0, e_valid = 0, e_end = 0, e_ack = 0, e_type = 0;
    logic [7:0]  e_data = 8'h0;
    logic [47:0] e_mac = 48'h0;

    task automatic build(input bit reply);
        logic [223:0] v;
        v = {16'h0001, 16'h0800, 8'h06, 8'h04, (reply ? 16'h0002 : 16'h0001),
             local_mac_addr, local_ip_addr,
             (reply ? arp_rec_source_mac_addr : 48'h0),
             (reply ? arp_rec_source_ip_addr : dest_ip_addr)};
        for (int i = 0; i < 256; i++) begin
            if (i < 28) m_frame[i] = v[223 - 8*i -: 8];
            else        m_frame[i] = 8'h00;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_wait = 0; m_grant = -1; m_pend = 0;
            e_req = 0; e_valid = 0; e_end = 0; e_ack = 0; e_type = 0;
            e_data = 8'h0; e_mac = 48'h0;
        end else begin
            m_n++;
            e_ack = 0;
            if (!m_wait && (m_grant < 0 || m_n >= m_grant + F + 2)) begin
                if (arp_reply_req) begin
                    build(1'b1);
                    e_type = 1; e_mac = arp_rec_source_mac_addr; e_ack = 1;
                    m_wait = 1; m_grant = -1;
                end else if (m_pend) begin
                    build(1'b0);
                    e_type = 0; e_mac = '1;
                    m_wait = 1; m_grant = -1; m_pend = 0;
                end
            end else if (m_wait && mac_tx_ack) begin
                m_wait = 0; m_grant = m_n;
            end
            if (arp_request_req) m_pend = 1;
            e_req = m_wait;
            if (m_grant >= 0 && (m_n - m_grant) < F) begin
                e_valid = 1;
                e_data  = m_frame[m_n - m_grant];
                e_end   = ((m_n - m_grant) == F - 1);
            end else begin
                e_valid = 0; e_data = 8'h0; e_end = 0;
            end
        end
    end

    logic [7:0] cap [0:255];
    int cap_n = 0, end_idx = -1, end_cyc = 0, frames = 0, ack_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("tx_req", arp_tx_req, e_req);
            chk("tx_valid", arp_tx_valid, e_valid);
            chk("tx_end", arp_tx_end, e_end);
            chk("reply_ack", arp_reply_ack, e_ack);
            if (e_valid) chk("tx_data", arp_tx_data, e_data);
            if (e_req || e_valid) begin
                chk("tx_type", arp_tx_type, e_type);
                chk("tx_dest_mac", arp_tx_dest_mac, e_mac);
            end
            if (arp_tx_valid && cap_n < 256) begin
                cap[cap_n] = arp_tx_data;
                cap_n++;
            end
            if (arp_tx_end) begin
                end_idx = cap_n - 1; end_cyc = m_n; frames++;
            end
            if (arp_reply_ack) ack_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        arp_request_req = 1'b0;
        mac_tx_ack = 1'b0;
        if (arp_reply_ack) arp_reply_req = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!arp_tx_req && n < 60) begin tick(); n++; end
        tests++;
        if (!arp_tx_req) begin
            fails++;
            $display("FAIL %s: arp_tx_req not seen within 60 cycles", name);
        end
    endtask

    task automatic wait_frame(input string name);
        int n, f0;
        n = 0; f0 = frames;
        while (frames == f0 && n < 200) begin tick(); n++; end
        tests++;
        if (frames == f0) begin
            fails++;
            $display("FAIL %s: arp_tx_end not seen within 200 cycles", name);
        end
    endtask

    task automatic grant();
        mac_tx_ack = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req"}, arp_tx_req, 0);
        chk({name, "_valid"}, arp_tx_valid, 0);
        chk({name, "_data"}, arp_tx_data, 0);
        chk({name, "_end"}, arp_tx_end, 0);
        chk({name, "_ack"}, arp_reply_ack, 0);
        chk({name, "_type"}, arp_tx_type, 0);
        chk({name, "_mac"}, arp_tx_dest_mac, 0);
    endtask

    function automatic logic [47:0] cap48(input int base);
        logic [47:0] r;
        r = 48'h0;
        for (int i = 0; i < 6; i++) r = {r[39:0], cap[base + i]};
        return r;
    endfunction

    function automatic logic [31:0] cap32(input int base);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) r = {r[23:0], cap[base + i]};
        return r;
    endfunction

    initial begin
        int hi, vs, nz, f0, rises;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) tick();

        // Reply to 192.168.1.2 / 00:11:22:33:44:55
        cap_n = 0; ack_cnt = 0;
        arp_rec_source_ip_addr  = 32'hC0A80102;
        arp_rec_source_mac_addr = 48'h001122334455;
        arp_reply_req = 1'b1;
        wait_req("reply_req");
        chk("reply_type", arp_tx_type, 1);
        chk("reply_dest_mac", arp_tx_dest_mac, 48'h001122334455);
        grant();
        wait_frame("reply_frame");
        chk("reply_len", cap_n, 46);
        chk("reply_end_idx", end_idx, 45);
        chk("reply_ack_count", ack_cnt, 1);
        chk("reply_hdr", cap48(0), 48'h000108000604);
        chk("reply_op", {cap[6], cap[7]}, 16'h0002);
        chk("reply_sha", cap48(8), 48'h02AABBCCDDEE);
        chk("reply_spa", cap32(14), 32'hC0A8010A);
        chk("reply_tha", cap48(18), 48'h001122334455);
        chk("reply_tpa", cap32(24), 32'hC0A80102);
        nz = 0;
        for (int i = 28; i < 46; i++) if (cap[i] != 8'h00) nz++;
        chk("reply_pad_nonzero", nz, 0);
        repeat (4) tick();

        // Request for 192.168.1.1, grant withheld 20 cycles
        cap_n = 0; ack_cnt = 0;
        dest_ip_addr = 32'hC0A80101;
        arp_request_req = 1'b1;
        tick();
        wait_req("request_req");
        chk("request_type", arp_tx_type, 0);
        chk("request_dest_mac", arp_tx_dest_mac, 48'hFFFFFFFFFFFF);
        hi = 0; vs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (arp_tx_req) hi++;
            if (arp_tx_valid) vs++;
        end
        chk("grant_delay_req_high", hi, 20);
        chk("grant_delay_no_valid", vs, 0);
        grant();
        chk("first_byte_valid", arp_tx_valid, 1);
        chk("req_low_after_grant", arp_tx_req, 0);
        wait_frame("request_frame");
        chk("request_len", cap_n, 46);
        chk("request_op", {cap[6], cap[7]}, 16'h0001);
        chk("request_tha", cap48(18), 48'h0);
        chk("request_tpa", cap32(24), 32'hC0A80101);
        chk("request_no_ack", ack_cnt, 0);
        repeat (4) tick();

        // Reply and request in the same cycle
        cap_n = 0;
        arp_reply_req = 1'b1;
        arp_request_req = 1'b1;
        tick();
        wait_req("both_first_req");
        chk("both_first_type", arp_tx_type, 1);
        grant();
        wait_frame("both_first_frame");
        chk("both_first_op", {cap[6], cap[7]}, 16'h0002);
        wait_req("both_second_req");
        chk("rerise_gap", m_n - end_cyc, 3);
        chk("both_second_type", arp_tx_type, 0);
        cap_n = 0;
        grant();
        wait_frame("both_second_frame");
        chk("both_second_op", {cap[6], cap[7]}, 16'h0001);
        repeat (4) tick();

        // Three request pulses during SEND merge into one frame
        arp_request_req = 1'b1;
        tick();
        wait_req("pulses_req");
        grant();
        repeat (5) tick();
        arp_request_req = 1'b1; tick(); tick();
        arp_request_req = 1'b1; tick(); tick();
        arp_request_req = 1'b1; tick();
        wait_frame("pulses_frame");
        f0 = frames; rises = 0;
        for (int i = 0; i < 150; i++) begin
            if (arp_tx_req) begin rises++; mac_tx_ack = 1'b1; end
            tick();
        end
        chk("pulses_extra_frames", frames - f0, 1);

        // Reset while byte 10 is on the output, with a request pending
        arp_request_req = 1'b1;
        tick();
        wait_req("reset_req");
        grant();
        repeat (5) tick();
        arp_request_req = 1'b1;
        tick();
        repeat (4) tick();
        chk("byte10_valid", arp_tx_valid, 1);
        chk("byte10_data", arp_tx_data, 8'hBB);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midframe_reset");
        tick(); tick();
        rst_n = 1'b1;
        f0 = frames; rises = 0;
        for (int i = 0; i < 80; i++) begin
            if (arp_tx_req) begin rises++; mac_tx_ack = 1'b1; end
            tick();
        end
        chk("post_reset_no_req", rises, 0);
        chk("post_reset_no_frame", frames - f0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
